// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, one-cycle exception flush, stall watchdog.
// Optional stall-cycle counter is built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int unsigned WD_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic [31:0] excp_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [15:0] WD_LIM16 = 16'(WD_LIMIT);

    state_t      state, state_nxt;
    logic [31:0] pc_q;
    logic [15:0] wd_cnt;
    logic        timeout_q;
    logic        any_req;

    assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = '0;
        flush     = 1'b0;
        case (state)
            RUN: begin
                if (stallreq_mem)     stall = 6'b011111;
                else if (stallreq_ex) stall = 6'b001111;
                else if (stallreq_id) stall = 6'b000111;
                if (flush_req) state_nxt = FLUSH;
            end
            FLUSH: begin
                flush     = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        // Hold nothing while in reset so downstream registers clear cleanly.
        if (!rst) stall = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst)                          pc_q <= '0;
        else if (state == RUN && flush_req) pc_q <= excp_pc;
    end

    assign new_pc = pc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state == RUN && any_req) begin
            if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)                   timeout_q <= 1'b0;
        else if (wd_cnt == WD_LIM16) timeout_q <= 1'b1;
    end

    assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (!rst)          cyc_q <= '0;
        else if (stall[0]) cyc_q <= cyc_q + 32'd1;
    end

    assign stall_cycles = cyc_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
